hero_write_rx: RTL and testbench

- Receive-side stage directly downstream of the hero write bus; consumes one hero_write_t beat per cycle.
- The hero write bus has no backpressure, so this block buffers beats in a small FIFO and re-presents them on a valid/ready interface to the bag-side consumer.
- Tracks transaction framing (VALID…DONE), marks the last beat, counts completed transactions and flags protocol and overflow errors.

---
 rtl/hero_write_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_hero_write_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hero_write_rx.sv
`default_nettype none
// ============================================================================
//  Module   : hero_write_rx
//  Purpose  : Receive stage for the hero write bus. The bus has no
//             backpressure, so incoming beats are framed (VALID...DONE),
//             tagged with a beat index and a last flag, and buffered in a
//             small FIFO. The FIFO is drained through a valid/ready port.
//             The block also counts completed transactions and keeps sticky
//             overflow and length error flags.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   core clock
//    rst_n         in   asynchronous active-low reset
//    hero_write    in   hero_write_t bus, packed as
//                         [59:58] cycle_type (0 IDLE, 1 VALID, 2 DONE)
//                         [57:22] wdat
//                         [21:1]  another_type_reference (unused)
//                         [0]     clk_en
//    out_valid     out  buffered beat available
//    out_ready     in   consumer accepts the beat
//    out_wdat      out  beat data
//    out_last      out  final beat of the transaction
//    out_beat_idx  out  0-based beat index within the transaction
//    xact_count    out  completed transactions, wraps at 2^16
//    err_clr       in   clears the sticky error flags
//    err_overflow  out  sticky: a beat was dropped on a full FIFO
//    err_len       out  sticky: a transaction hit MAX_BEATS without DONE
//    fifo_level    out  current FIFO occupancy
// ============================================================================
module hero_write_rx #(
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int HERO_WRITE_T_WIDTH = 60,
  localparam int HERO_WIDTH         = 36,
  localparam int LVL_W              = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [HERO_WRITE_T_WIDTH-1:0] hero_write,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [HERO_WIDTH-1:0]         out_wdat,
  output logic                          out_last,
  output logic [7:0]                    out_beat_idx,
  output logic [15:0]                   xact_count,
  input  logic                          err_clr,
  output logic                          err_overflow,
  output logic                          err_len,
  output logic [LVL_W-1:0]              fifo_level
);

  localparam int         C_ADDR_W   = $clog2(DEPTH);
  localparam int         C_PTR_W    = C_ADDR_W + 1;
  localparam int         C_ENTRY_W  = HERO_WIDTH + 1 + 8;
  localparam logic [1:0] C_CT_VALID = 2'd1;
  localparam logic [1:0] C_CT_DONE  = 2'd2;
  localparam logic [7:0] C_LAST_IDX = 8'(MAX_BEATS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XACT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Bus field extraction and beat qualification
  // --------------------------------------------------------------------------
  logic [1:0]            w_cycle_type;
  logic [HERO_WIDTH-1:0] w_wdat;
  logic                  w_clk_en;
  logic                  w_beat_in;
  logic                  w_is_done;
  logic                  w_unused_ref;

  assign w_cycle_type = hero_write[59:58];
  assign w_wdat       = hero_write[57:22];
  assign w_clk_en     = hero_write[0];
  assign w_unused_ref = ^hero_write[21:1];

  assign w_is_done = (w_cycle_type == C_CT_DONE);
  assign w_beat_in = w_clk_en & ((w_cycle_type == C_CT_VALID) | w_is_done);

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       w_push;
  logic       w_push_last;
  logic [7:0] w_push_idx;
  logic       w_xact_done;
  logic       w_len_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_push_idx  = 8'd0;
    w_xact_done = 1'b0;
    w_len_event = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_beat_in) begin
          w_push = 1'b1;
          if (w_is_done) begin
            // Lone DONE is a complete single-beat transaction.
            w_push_last = 1'b1;
            w_xact_done = 1'b1;
          end else begin
            w_state_nxt = S_XACT;
            w_cnt_nxt   = 8'd1;
          end
        end
      end
      S_XACT: begin
        if (w_beat_in) begin
          w_push     = 1'b1;
          w_push_idx = r_cnt;
          if (w_is_done || (r_cnt == C_LAST_IDX)) begin
            // Either a proper DONE or a forced close at the length limit;
            // both mark the beat last so the consumer stays framed.
            w_push_last = 1'b1;
            w_xact_done = 1'b1;
            w_len_event = ~w_is_done;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Beat FIFO: pointers carry one extra wrap bit to tell full from empty
  // --------------------------------------------------------------------------
  logic [C_ENTRY_W-1:0] r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [C_PTR_W-1:0]   w_level;
  logic                 w_full, w_empty, w_pop, w_push_ok, w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[C_PTR_W-1] != r_rd_ptr[C_PTR_W-1]) &&
                   (r_wr_ptr[C_ADDR_W-1:0] == r_rd_ptr[C_ADDR_W-1:0]);
  assign w_level = r_wr_ptr - r_rd_ptr;

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  // Storage is reset so the output never shows X while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr[C_ADDR_W-1:0]] <= {w_wdat, w_push_last, w_push_idx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign {out_wdat, out_last, out_beat_idx} = r_mem[r_rd_ptr[C_ADDR_W-1:0]];
  assign fifo_level = LVL_W'(w_level);

  // --------------------------------------------------------------------------
  // Transaction counter and sticky error flags (a new event beats a clear)
  // --------------------------------------------------------------------------
  logic [15:0] r_xact_count;
  logic        r_err_overflow, r_err_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xact_count   <= 16'd0;
      r_err_overflow <= 1'b0;
      r_err_len      <= 1'b0;
    end else begin
      if (w_xact_done) r_xact_count <= r_xact_count + 16'd1;

      if (w_drop)       r_err_overflow <= 1'b1;
      else if (err_clr) r_err_overflow <= 1'b0;

      if (w_len_event)  r_err_len <= 1'b1;
      else if (err_clr) r_err_len <= 1'b0;
    end
  end

  assign xact_count   = r_xact_count;
  assign err_overflow = r_err_overflow;
  assign err_len      = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_hero_write_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hero_write_rx
//  Purpose  : Self-checking bench for hero_write_rx. A queue-based reference
//             model tracks expected FIFO contents, framing, transaction count
//             and error flags; directed table vectors and corner-case
//             sequences add independent hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hero_write_rx;

  localparam int DEPTH     = 8;
  localparam int MAX_BEATS = 16;
  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;

  logic        clk;
  logic        rst_n;
  logic [59:0] hero_write;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_wdat;
  logic        out_last;
  logic [7:0]  out_beat_idx;
  logic [15:0] xact_count;
  logic        err_clr;
  logic        err_overflow;
  logic        err_len;
  logic [3:0]  fifo_level;

  hero_write_rx #(.DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hero_write   (hero_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_wdat     (out_wdat),
    .out_last     (out_last),
    .out_beat_idx (out_beat_idx),
    .xact_count   (xact_count),
    .err_clr      (err_clr),
    .err_overflow (err_overflow),
    .err_len      (err_len),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: expected beat queue plus framing/counter/flag state
  // --------------------------------------------------------------------------
  typedef struct {
    logic [35:0] wdat;
    logic        last;
    logic [7:0]  idx;
  } beat_t;

  beat_t m_q[$];
  beat_t cap[$];
  bit    m_in_xact;
  int    m_cnt;
  int    m_xcnt;
  bit    m_ovf;
  bit    m_len;

  function automatic void model_reset();
    m_q.delete();
    m_in_xact = 0;
    m_cnt     = 0;
    m_xcnt    = 0;
    m_ovf     = 0;
    m_len     = 0;
  endfunction

  function automatic void model_check();
    chk("m_valid", out_valid, m_q.size() != 0);
    chk("m_level", fifo_level, m_q.size());
    chk("m_xcnt", xact_count, m_xcnt);
    chk("m_ovf", err_overflow, m_ovf);
    chk("m_len", err_len, m_len);
    if (m_q.size() != 0) begin
      chk("m_wdat", out_wdat, m_q[0].wdat);
      chk("m_last", out_last, m_q[0].last);
      chk("m_idx", out_beat_idx, m_q[0].idx);
    end
  endfunction

  function automatic void model_step(logic [1:0] ct, logic [35:0] d, logic en,
                                     logic rdy, logic clr);
    bit    ev_ovf = 0;
    bit    ev_len = 0;
    bit    done;
    int    idx;
    beat_t b;
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (en && (ct == CT_VALID || ct == CT_DONE)) begin
      done   = (ct == CT_DONE);
      idx    = m_in_xact ? m_cnt : 0;
      b.wdat = d;
      b.idx  = 8'(idx);
      b.last = done || (idx == MAX_BEATS - 1);
      ev_len = !done && (idx == MAX_BEATS - 1);
      if (b.last) begin
        m_in_xact = 0;
        m_cnt     = 0;
        m_xcnt    = (m_xcnt + 1) % 65536;
      end else begin
        m_in_xact = 1;
        m_cnt     = idx + 1;
      end
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else ev_ovf = 1;
    end
    if (ev_ovf) m_ovf = 1; else if (clr) m_ovf = 0;
    if (ev_len) m_len = 1; else if (clr) m_len = 0;
  endfunction

  // Drive one cycle: apply inputs, check outputs against the model, record
  // any beat the consumer takes, advance the model, step past the edge.
  task automatic cyc(input logic [1:0] ct, input logic [35:0] d, input logic en,
                     input logic rdy, input logic clr);
    hero_write = {ct, d, 21'($urandom), en};
    out_ready  = rdy;
    err_clr    = clr;
    model_check();
    if (out_valid && rdy) cap.push_back('{out_wdat, out_last, out_beat_idx});
    model_step(ct, d, en, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed vectors: {inputs, expected outputs after the edge}
  // --------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  ct;
    logic [35:0] d;
    logic        en;
    logic        rdy;
    logic        ev;
    logic [35:0] ed;
    logic        el;
    logic [7:0]  ei;
    logic [15:0] ex;
    logic [3:0]  elvl;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // single-beat transaction
    tbl[0] = '{CT_DONE,  36'hA_5A5A_5A5A, 1'b1, 1'b1, 1'b1, 36'hA_5A5A_5A5A, 1'b1, 8'd0, 16'd1, 4'd1};
    tbl[1] = '{CT_IDLE,  36'h0,           1'b1, 1'b1, 1'b0, 36'h0,           1'b0, 8'd0, 16'd1, 4'd0};
    // multi-beat with an IDLE gap and a clk_en=0 gap
    tbl[2] = '{CT_VALID, 36'h1_0000_0001, 1'b1, 1'b1, 1'b1, 36'h1_0000_0001, 1'b0, 8'd0, 16'd1, 4'd1};
    tbl[3] = '{CT_IDLE,  36'h0,           1'b1, 1'b1, 1'b0, 36'h0,           1'b0, 8'd0, 16'd1, 4'd0};
    tbl[4] = '{CT_VALID, 36'h2_0000_0002, 1'b0, 1'b1, 1'b0, 36'h0,           1'b0, 8'd0, 16'd1, 4'd0};
    tbl[5] = '{CT_VALID, 36'h2_0000_0002, 1'b1, 1'b1, 1'b1, 36'h2_0000_0002, 1'b0, 8'd1, 16'd1, 4'd1};
    tbl[6] = '{CT_DONE,  36'h3_0000_0003, 1'b1, 1'b1, 1'b1, 36'h3_0000_0003, 1'b1, 8'd2, 16'd2, 4'd1};
    tbl[7] = '{CT_IDLE,  36'h0,           1'b1, 1'b1, 1'b0, 36'h0,           1'b0, 8'd0, 16'd2, 4'd0};
  end

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int pct;
    int r;
    logic [1:0] ct;

    rst_n      = 1'b0;
    hero_write = '0;
    out_ready  = 1'b0;
    err_clr    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // Reset state: every output is zero.
    chk("rst_valid", out_valid, 0);
    chk("rst_wdat", out_wdat, 0);
    chk("rst_last", out_last, 0);
    chk("rst_idx", out_beat_idx, 0);
    chk("rst_xcnt", xact_count, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_len", err_len, 0);
    chk("rst_level", fifo_level, 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].ct, tbl[i].d, tbl[i].en, tbl[i].rdy, 1'b0);
      chk("tbl_valid", out_valid, tbl[i].ev);
      chk("tbl_xcnt", xact_count, tbl[i].ex);
      chk("tbl_level", fifo_level, tbl[i].elvl);
      if (tbl[i].ev) begin
        chk("tbl_wdat", out_wdat, tbl[i].ed);
        chk("tbl_last", out_last, tbl[i].el);
        chk("tbl_idx", out_beat_idx, tbl[i].ei);
      end
    end

    // Overflow: 10 VALID + DONE with consumer stalled
    for (int i = 0; i < 10; i++) cyc(CT_VALID, 36'(64'h100 + i), 1'b1, 1'b0, 1'b0);
    cyc(CT_DONE, 36'h1FF, 1'b1, 1'b0, 1'b0);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_flag", err_overflow, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_valid", out_valid, 1);
      chk("ovf_drain_idx", out_beat_idx, i);
      chk("ovf_drain_wdat", out_wdat, 36'(64'h100 + i));
      cyc(CT_IDLE, 36'h0, 1'b1, 1'b1, 1'b0);
    end
    chk("ovf_drained", out_valid, 0);
    chk("ovf_still_set", err_overflow, 1);
    cyc(CT_IDLE, 36'h0, 1'b1, 1'b1, 1'b1);
    chk("ovf_cleared", err_overflow, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(CT_DONE, 36'(64'h200 + i), 1'b1, 1'b0, 1'b0);
    chk("full_level", fifo_level, 8);
    for (int i = 0; i < 20; i++) begin
      cyc(CT_DONE, 36'(64'h300 + i), 1'b1, 1'b1, 1'b0);
      chk("pp_level", fifo_level, 8);
      chk("pp_ovf", err_overflow, 0);
    end

    // Length limit: 20 VALID beats, consumer always ready
    for (int i = 0; i < 10; i++) cyc(CT_IDLE, 36'h0, 1'b1, 1'b1, 1'b0);
    cap.delete();
    for (int i = 0; i < 20; i++) cyc(CT_VALID, 36'(64'h400 + i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(CT_IDLE, 36'h0, 1'b1, 1'b1, 1'b0);
    chk("len_count", cap.size(), 20);
    if (cap.size() == 20) begin
      chk("len_idx15", cap[15].idx, 15);
      chk("len_last15", cap[15].last, 1);
      chk("len_last14", cap[14].last, 0);
      for (int i = 16; i < 20; i++) begin
        chk("len_new_idx", cap[i].idx, i - 16);
        chk("len_new_last", cap[i].last, 0);
      end
    end
    chk("len_flag", err_len, 1);

    // Async reset mid-transaction
    for (int i = 0; i < 3; i++) cyc(CT_VALID, 36'(64'h500 + i), 1'b1, 1'b0, 1'b0);
    chk("ar_level_pre", fifo_level, 3);
    hero_write = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_level", fifo_level, 0);
    chk("ar_xcnt", xact_count, 0);
    chk("ar_ovf", err_overflow, 0);
    chk("ar_len", err_len, 0);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(CT_DONE, 36'h6_1234_5678, 1'b1, 1'b1, 1'b0);
    chk("ar_done_valid", out_valid, 1);
    chk("ar_done_idx", out_beat_idx, 0);
    chk("ar_done_last", out_last, 1);
    chk("ar_done_wdat", out_wdat, 36'h6_1234_5678);

    // Randomized traffic against the model
    for (int blk = 0; blk < 10; blk++) begin
      pct = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        r = $urandom_range(0, 99);
        if (r < 25)      ct = CT_IDLE;
        else if (r < 80) ct = CT_VALID;
        else if (r < 95) ct = CT_DONE;
        else             ct = 2'd3;
        cyc(ct, {4'($urandom), 32'($urandom)},
            ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < pct),
            ($urandom_range(0, 99) < 3));
      end
    end
    model_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
